// File: rtl/proc_pkg.sv
// Shared definitions for the program sequencer and the fetch-stage interface.
// Program-select codes match the fetch stage's start-address decode.
package proc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    NEXT,
    DONE
  } prog_seq_state_t;

  localparam int PROG_SEL_W = 2;

  localparam logic [PROG_SEL_W-1:0] PROG_0 = 2'd0;
  localparam logic [PROG_SEL_W-1:0] PROG_1 = 2'd1;
  localparam logic [PROG_SEL_W-1:0] PROG_2 = 2'd2;
  localparam logic [PROG_SEL_W-1:0] PROG_3 = 2'd3;

endpackage

// File: rtl/run_timer.sv
// Run-length counter for one program.
// Flags the last allowed cycle and captures the inclusive run length.
module run_timer #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             capture,
  output logic [CNT_W-1:0] count,
  output logic             terminal,
  output logic [CNT_W-1:0] captured
);

  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] run_len;

  assign terminal = (count == LAST);
  // count is zero-based, so the inclusive length is count+1, never above TIMEOUT
  assign run_len  = (count >= LAST) ? LIMIT : count + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      captured <= '0;
    end else begin
      if (clear) begin
        count <= '0;
      end else if (enable) begin
        count <= count + CNT_W'(1);
      end
      if (capture) begin
        captured <= run_len;
      end
    end
  end

endmodule

// File: rtl/prog_seq.sv
// Program sequencer: runs programs 0..NUM_PROGS-1 through the fetch stage,
// measuring each run length and aborting programs that never halt.
module prog_seq
  import proc_pkg::*;
#(
  parameter int NUM_PROGS   = 3,
  parameter int INIT_CYCLES = 2,
  parameter int TIMEOUT     = 4096,
  parameter int CNT_W       = 16
) (
  input  logic                  CLK,
  input  logic                  Reset_n,
  input  logic                  Start,
  input  logic                  Halt,
  output logic                  Init,
  output logic [PROG_SEL_W-1:0] ProgState,
  output logic                  Busy,
  output logic                  Done,
  output logic                  CycleValid,
  output logic [CNT_W-1:0]      CycleCount,
  output logic                  TimedOut,
  output prog_seq_state_t       fsm_state
);

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [INIT_W-1:0]     INIT_LOAD = INIT_W'(INIT_CYCLES - 1);
  localparam logic [PROG_SEL_W-1:0] LAST_PROG = PROG_SEL_W'(NUM_PROGS - 1);

  if (NUM_PROGS < 1 || NUM_PROGS > 4) begin : g_bad_num_progs
    $error("prog_seq: NUM_PROGS must be 1..4");
  end
  if (INIT_CYCLES < 1) begin : g_bad_init_cycles
    $error("prog_seq: INIT_CYCLES must be at least 1");
  end
  if (TIMEOUT < 2 || longint'(TIMEOUT) > (longint'(1) << CNT_W) - 1) begin : g_bad_timeout
    $error("prog_seq: TIMEOUT must be 2..2^CNT_W-1 so run_cnt cannot wrap");
  end

  prog_seq_state_t         state, state_d;
  logic [PROG_SEL_W-1:0]   prog, prog_d;
  logic [INIT_W-1:0]       init_cnt, init_cnt_d;
  logic                    timed_out, timed_out_d;

  logic                    tmr_clear, tmr_enable, tmr_capture, tmr_terminal;
  logic [CNT_W-1:0]        run_cnt;
  logic                    halt_valid;

  // Halt may still be high from the previous program during the first RUN cycle
  assign halt_valid = Halt && (run_cnt != '0);

  run_timer #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_run_timer (
    .clk      (CLK),
    .rst_n    (Reset_n),
    .clear    (tmr_clear),
    .enable   (tmr_enable),
    .capture  (tmr_capture),
    .count    (run_cnt),
    .terminal (tmr_terminal),
    .captured (CycleCount)
  );

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      prog      <= PROG_0;
      init_cnt  <= '0;
      timed_out <= 1'b0;
    end else begin
      state     <= state_d;
      prog      <= prog_d;
      init_cnt  <= init_cnt_d;
      timed_out <= timed_out_d;
    end
  end

  always_comb begin
    state_d     = state;
    prog_d      = prog;
    init_cnt_d  = init_cnt;
    timed_out_d = timed_out;
    tmr_clear   = 1'b0;
    tmr_enable  = 1'b0;
    tmr_capture = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          state_d     = INIT;
          prog_d      = PROG_0;
          init_cnt_d  = INIT_LOAD;
          timed_out_d = 1'b0;
        end
      end
      INIT: begin
        if (init_cnt == '0) begin
          state_d   = RUN;
          tmr_clear = 1'b1;
        end else begin
          init_cnt_d = init_cnt - INIT_W'(1);
        end
      end
      RUN: begin
        tmr_enable = 1'b1;
        // A valid halt on the terminal cycle wins over the timeout
        if (halt_valid || tmr_terminal) begin
          state_d     = NEXT;
          tmr_capture = 1'b1;
          if (!halt_valid) begin
            timed_out_d = 1'b1;
          end
        end
      end
      NEXT: begin
        if (prog == LAST_PROG) begin
          state_d = DONE;
        end else begin
          prog_d     = prog + PROG_SEL_W'(1);
          init_cnt_d = INIT_LOAD;
          state_d    = INIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Init       = (state != RUN);
  assign ProgState  = (state == IDLE) ? PROG_0 : prog;
  assign Busy       = (state != IDLE);
  assign Done       = (state == DONE);
  assign CycleValid = (state == NEXT);
  assign TimedOut   = timed_out;
  assign fsm_state  = state;

endmodule

// File: tb/tb_prog_seq.sv
// Directed bench for prog_seq: a default instance (A) and a TIMEOUT=16,
// NUM_PROGS=2 instance (B), each with a halt responder and result scoreboard.
module tb_prog_seq;
  import proc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic start_a = 1'b0, halt_a = 1'b0;
  logic init_a, busy_a, done_a, cycle_valid_a, timed_out_a;
  logic [1:0] prog_state_a;
  logic [15:0] cycle_count_a;
  prog_seq_state_t fsm_state_a;

  logic start_b = 1'b0, halt_b = 1'b0;
  logic init_b, busy_b, done_b, cycle_valid_b, timed_out_b;
  logic [1:0] prog_state_b;
  logic [15:0] cycle_count_b;
  prog_seq_state_t fsm_state_b;

  int checks = 0;
  int errors = 0;

  // scoreboard entries are {prog, cycle_count}
  logic [17:0] exp_q_a[$];
  logic [17:0] exp_q_b[$];

  int len_a[4] = '{0, 0, 0, 0};
  int len_b[4] = '{0, 0, 0, 0};
  bit stale_a = 1'b0;
  int k_a = 0, k_b = 0;
  int done_cnt_a = 0, done_cnt_b = 0;

  prog_seq u_dut_a (
    .CLK        (clk),
    .Reset_n    (rst_n),
    .Start      (start_a),
    .Halt       (halt_a),
    .Init       (init_a),
    .ProgState  (prog_state_a),
    .Busy       (busy_a),
    .Done       (done_a),
    .CycleValid (cycle_valid_a),
    .CycleCount (cycle_count_a),
    .TimedOut   (timed_out_a),
    .fsm_state  (fsm_state_a)
  );

  prog_seq #(
    .NUM_PROGS   (2),
    .INIT_CYCLES (2),
    .TIMEOUT     (16),
    .CNT_W       (16)
  ) u_dut_b (
    .CLK        (clk),
    .Reset_n    (rst_n),
    .Start      (start_b),
    .Halt       (halt_b),
    .Init       (init_b),
    .ProgState  (prog_state_b),
    .Busy       (busy_b),
    .Done       (done_b),
    .CycleValid (cycle_valid_b),
    .CycleCount (cycle_count_b),
    .TimedOut   (timed_out_b),
    .fsm_state  (fsm_state_b)
  );

  // clock
  initial forever #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Halt responder and result monitor, instance A.
  // k_a is the 1-based RUN cycle; halt goes high on RUN cycle len_a[prog].
  always @(negedge clk) begin
    logic [17:0] e;
    if (init_a) k_a = 0;
    else        k_a = k_a + 1;
    if (init_a) halt_a = stale_a;
    else        halt_a = (k_a == len_a[prog_state_a]) || (stale_a && k_a == 1);
    if (done_a) done_cnt_a++;
    if (cycle_valid_a) begin
      check_eq("a_sb_nonempty", exp_q_a.size() != 0, 1);
      if (exp_q_a.size() != 0) begin
        e = exp_q_a.pop_front();
        check_eq("a_result", {prog_state_a, cycle_count_a}, e);
      end
    end
  end

  always @(negedge clk) begin
    logic [17:0] e;
    if (init_b) k_b = 0;
    else        k_b = k_b + 1;
    halt_b = !init_b && (k_b == len_b[prog_state_b]);
    if (done_b) done_cnt_b++;
    if (cycle_valid_b) begin
      check_eq("b_sb_nonempty", exp_q_b.size() != 0, 1);
      if (exp_q_b.size() != 0) begin
        e = exp_q_b.pop_front();
        check_eq("b_result", {prog_state_b, cycle_count_b}, e);
      end
    end
  end

  // Start pulse on A, checking Start-to-Init-low latency of 1 + INIT_CYCLES.
  task automatic start_seq_a();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check_eq("a_busy_after_start", busy_a, 1);
    check_eq("a_init_cyc1", init_a, 1);
    @(negedge clk);
    check_eq("a_init_cyc2", init_a, 1);
    @(negedge clk);
    check_eq("a_init_low_latency", init_a, 0);
  endtask

  task automatic start_seq_b();
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check_eq("b_timedout_cleared", timed_out_b, 0);
  endtask

  task automatic wait_done(input bit sel, input int budget);
    int base;
    int n;
    base = sel ? done_cnt_b : done_cnt_a;
    n = 0;
    while (((sel ? done_cnt_b : done_cnt_a) == base) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq(sel ? "b_done_seen" : "a_done_seen", (sel ? done_cnt_b : done_cnt_a) - base, 1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_eq("rst_init", init_a, 1);
    check_eq("rst_prog", prog_state_a, 0);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_done", done_a, 0);
    check_eq("rst_valid", cycle_valid_a, 0);
    check_eq("rst_count", cycle_count_a, 0);
    check_eq("rst_timedout", timed_out_a, 0);
    check_eq("rst_state", fsm_state_a, IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    // three programs halting after 20, 10, 5 RUN cycles
    len_a = '{20, 10, 5, 0};
    exp_q_a.push_back({2'd0, 16'd20});
    exp_q_a.push_back({2'd1, 16'd10});
    exp_q_a.push_back({2'd2, 16'd5});
    start_seq_a();
    wait_done(1'b0, 2000);
    check_eq("a_seq1_done_cnt", done_cnt_a, 1);
    check_eq("a_seq1_timedout", timed_out_a, 0);
    repeat (3) @(negedge clk);
    check_eq("a_seq1_idle", busy_a, 0);

    // stale halt through INIT, plus a Start pulse during RUN of prog 0
    stale_a = 1'b1;
    len_a = '{8, 6, 4, 0};
    exp_q_a.push_back({2'd0, 16'd8});
    exp_q_a.push_back({2'd1, 16'd6});
    exp_q_a.push_back({2'd2, 16'd4});
    start_seq_a();
    repeat (3) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(1'b0, 2000);
    repeat (5) @(negedge clk);
    check_eq("a_seq2_done_cnt", done_cnt_a, 2);
    check_eq("a_seq2_idle", busy_a, 0);
    stale_a = 1'b0;

    // reset in the middle of prog 1 with run_cnt = 37
    len_a = '{10, 1000, 1000, 0};
    exp_q_a.push_back({2'd0, 16'd10});
    start_seq_a();
    n = 0;
    while (!(prog_state_a == 2'd1 && init_a == 1'b0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("a_reached_prog1", {prog_state_a, init_a}, {2'd1, 1'b0});
    repeat (37) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_init", init_a, 1);
    check_eq("midrst_prog", prog_state_a, 0);
    check_eq("midrst_busy", busy_a, 0);
    check_eq("midrst_timedout", timed_out_a, 0);
    check_eq("midrst_done", done_a, 0);
    check_eq("midrst_state", fsm_state_a, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("midrst_no_done", done_cnt_a, 2);

    // B: prog 0 never halts (timeout), prog 1 halts after 6
    len_b = '{0, 6, 0, 0};
    exp_q_b.push_back({2'd0, 16'd16});
    exp_q_b.push_back({2'd1, 16'd6});
    start_seq_b();
    wait_done(1'b1, 2000);
    check_eq("b_timedout_set", timed_out_b, 1);

    // B: halts land exactly on run_cnt = TIMEOUT-1
    len_b = '{16, 16, 0, 0};
    exp_q_b.push_back({2'd0, 16'd16});
    exp_q_b.push_back({2'd1, 16'd16});
    repeat (2) @(negedge clk);
    start_seq_b();
    wait_done(1'b1, 2000);
    check_eq("b_edge_no_timeout", timed_out_b, 0);
    check_eq("b_done_cnt", done_cnt_b, 2);

    repeat (3) @(negedge clk);
    check_eq("a_sb_drained", exp_q_a.size(), 0);
    check_eq("b_sb_drained", exp_q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_seq.md
# prog_seq

Program sequencer upstream of the instruction-fetch stage. It drives the fetch stage's `Init` and `ProgState` inputs and watches its registered `Halt` output. On a start request it runs programs 0..NUM_PROGS-1 back to back: it holds fetch in init while selecting each program's start address, releases it, and measures the run length in cycles. A watchdog aborts a program that never halts. It signals completion to the testbench/top level.

## Interface
- `NUM_PROGS`, 3: number of programs run per start; legal 1..4, since `ProgState` is 2 bits.
- `INIT_CYCLES`, 2: cycles `Init` is held high before each program; legal ≥1.
- `TIMEOUT`, 4096: maximum RUN cycles per program before abort; legal 2..2^CNT_W-1.
- `CNT_W`, 16: width of the cycle counter.
- `CLK`  in  1  single clock; all state changes on posedge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Start`  in  1  run request; sampled in IDLE only.
- `Halt`  in  1  registered halt flag from fetch.
- `Init`  out  1  hold fetch in init/reset.
- `ProgState`  out  2  program select to fetch.
- `Busy`  out  1  high in every state except IDLE.
- `Done`  out  1  one-cycle pulse when the last program finishes.
- `CycleValid`  out  1  one-cycle pulse; `CycleCount` is valid.
- `CycleCount`  out  CNT_W  run length of the program just finished.
- `TimedOut`  out  1  sticky; a program hit `TIMEOUT` since the last start.

## Operation
- States: IDLE, INIT, RUN, NEXT, DONE. Internal registers: `prog` (2b), `init_cnt`, `run_cnt` (CNT_W).
- Reset values: state=IDLE, `Init`=1, `ProgState`=0, `Busy`=0, `Done`=0, `CycleValid`=0, `CycleCount`=0, `TimedOut`=0.
- **IDLE:** `Init`=1, `ProgState`=0.
  - `Start`=1 → INIT, with `prog`=0, `init_cnt`=INIT_CYCLES-1, and `TimedOut` cleared.
- **INIT:** `Init`=1, `ProgState`=`prog`.
  - `init_cnt` decrements each cycle.
  - At 0 → RUN with `run_cnt`=0.
- **RUN:** `Init`=0, `ProgState`=`prog`. `run_cnt` increments each cycle.
  - `Halt` is ignored while `run_cnt`==0. Fetch does not update `Halt` during init, so it may still hold the previous program's 1.
  - `Halt`=1 with `run_cnt`≥1: `CycleCount`←`run_cnt`+1, `CycleValid` pulses next cycle, → NEXT.
  - `run_cnt`==TIMEOUT-1 without a valid `Halt`: `CycleCount`←TIMEOUT, `TimedOut`←1, `CycleValid` pulses, → NEXT.
  - Simultaneous valid `Halt` and timeout: treat as halt; `TimedOut` is not set.
- **NEXT:** `Init`=1.
  - If `prog`==NUM_PROGS-1 → DONE.
  - Otherwise `prog`++, `init_cnt`=INIT_CYCLES-1, → INIT.
- **DONE:** `Init`=1, `Done`=1 for this one cycle, → IDLE.
- `Start` outside IDLE is ignored; no queuing.
- `Start` held high in IDLE after DONE begins a new sequence on the next cycle.
- `Reset_n` low at any time forces all reset values immediately, mid-program included.

## Timing
- Start-to-`Init`-low latency: 1 + INIT_CYCLES cycles (IDLE sample, then INIT_CYCLES cycles of INIT).
- `CycleCount` counts RUN cycles inclusive: first `Init`-low cycle through the cycle `Halt` is seen.
- `CycleValid` and the NEXT state coincide (one cycle).
- `Init` rises the cycle after the halt is observed. Fetch has then advanced PC by one more, which is harmless because init reloads PC.
- Per-program overhead between programs: NEXT (1) + INIT (INIT_CYCLES).
- `run_cnt` cannot wrap: `TIMEOUT`≤2^CNT_W-1 is enforced by an elaboration-time assertion.

## Structure
- Shared package `proc_pkg` holds:
  - `prog_seq_state_t` enum {IDLE, INIT, RUN, NEXT, DONE};
  - `PROG_SEL_W`=2;
  - named program-select constants `PROG_0`..`PROG_3`, matching the fetch stage's start-address decode.
- One natural sub-module, `run_timer`: a CNT_W counter with clear, enable, a terminal-count compare against TIMEOUT-1, and a saturating capture. The FSM stays in `prog_seq`.

## Test plan
- Reset mid-RUN (prog 1, `run_cnt`=37), `Reset_n` low → same-cycle `Init`=1, `ProgState`=0, `Busy`=0, `TimedOut`=0; no `Done`.
- NUM_PROGS=3, INIT_CYCLES=2, halts after 20/10/5 RUN cycles → `CycleCount` 20, 10, 5 with three `CycleValid` pulses, `ProgState` 0→1→2, a single `Done`, `TimedOut`=0.
- Stale `Halt`=1 held through INIT into the first RUN cycle → ignored; the program runs until a fresh `Halt` at cycle 8 → `CycleCount`=8.
- TIMEOUT=16, `Halt` never asserted → `CycleCount`=16, `TimedOut`=1, sequencer advances to the next program; the next `Start` clears `TimedOut`.
- `Start` pulsed during RUN of prog 0 → ignored; exactly one `Done`.
- `Halt` asserted exactly on the cycle with `run_cnt`=TIMEOUT-1 → `CycleCount`=TIMEOUT, `TimedOut` stays 0.
